// File: rtl/bp_fe_parcel_realigner.sv
// Circular parcel buffer between I$ fetch and decode; emits one realigned 16/32-bit instruction per cycle.
// Latency: a block accepted in cycle N is visible on instr_* in cycle N+1; all outputs decode from registered state.
// Backpressure: fetch_ready_o drops while free space < one block, judged on the registered count only.
module bp_fe_parcel_realigner #(
    parameter int vaddr_width_p    = 39,
    parameter int fetch_width_p    = 64,
    parameter int buffer_parcels_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     fetch_v_i,
    input  logic [vaddr_width_p-1:0] fetch_pc_i,
    input  logic [fetch_width_p-1:0] fetch_data_i,
    output logic                     fetch_ready_o,
    input  logic                     redirect_v_i,
    input  logic [vaddr_width_p-1:0] redirect_pc_i,
    input  logic                     redirect_partial_v_i,
    input  logic [15:0]              redirect_partial_i,
    output logic                     instr_v_o,
    output logic [31:0]              instr_o,
    output logic [vaddr_width_p-1:0] instr_pc_o,
    output logic                     instr_compressed_o,
    output logic                     instr_split_err_o,
    input  logic                     instr_yumi_i
);

    localparam int P   = fetch_width_p / 16;
    localparam int LGP = $clog2(P);
    localparam int PW  = $clog2(buffer_parcels_p);
    localparam int CW  = $clog2(buffer_parcels_p + 1);

    logic [15:0]              r_parcel [buffer_parcels_p];
    logic [vaddr_width_p-1:0] r_pc     [buffer_parcels_p];
    logic [PW-1:0]            r_head;
    logic [PW-1:0]            r_tail;
    logic [CW-1:0]            r_count;

    logic [PW-1:0]            w_head1;
    logic [15:0]              w_p0;
    logic [15:0]              w_p1;
    logic [vaddr_width_p-1:0] w_pc0;
    logic [vaddr_width_p-1:0] w_pc1;
    logic                     w_comp;
    logic                     w_discontig;
    logic                     w_split;
    logic                     w_single;
    logic [CW-1:0]            w_free;
    logic [LGP-1:0]           w_offset;
    logic                     w_push;
    logic                     w_pop;
    logic [CW-1:0]            w_push_n;
    logic [CW-1:0]            w_pop_n;

    assign w_head1     = r_head + PW'(1);
    assign w_p0        = r_parcel[r_head];
    assign w_p1        = r_parcel[w_head1];
    assign w_pc0       = r_pc[r_head];
    assign w_pc1       = r_pc[w_head1];
    assign w_comp      = (w_p0[1:0] != 2'b11);
    assign w_discontig = (w_pc1 != (w_pc0 + vaddr_width_p'(2)));

    // A 32-bit head only becomes an instruction once a second parcel exists.
    assign w_split     = ~w_comp & (r_count >= CW'(2)) & w_discontig;
    assign w_single    = w_comp | w_split;

    assign instr_v_o          = ((r_count >= CW'(1)) & w_comp) | ((r_count >= CW'(2)) & ~w_comp);
    assign instr_o            = w_single ? {16'h0000, w_p0} : {w_p1, w_p0};
    assign instr_pc_o         = w_pc0;
    assign instr_compressed_o = w_comp;
    assign instr_split_err_o  = w_split;

    assign w_free        = CW'(buffer_parcels_p) - r_count;
    assign fetch_ready_o = (w_free >= CW'(P));

    assign w_offset = fetch_pc_i[LGP:1];
    assign w_push   = fetch_v_i & fetch_ready_o & ~redirect_v_i;
    assign w_pop    = instr_yumi_i & instr_v_o & ~redirect_v_i;
    assign w_push_n = w_push ? (CW'(P) - CW'(w_offset)) : CW'(0);
    assign w_pop_n  = w_pop ? (w_single ? CW'(1) : CW'(2)) : CW'(0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect_v_i) begin
            r_head  <= '0;
            r_tail  <= redirect_partial_v_i ? PW'(1) : PW'(0);
            r_count <= redirect_partial_v_i ? CW'(1) : CW'(0);
        end else begin
            r_head  <= r_head + PW'(w_pop_n);
            r_tail  <= r_tail + PW'(w_push_n);
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    // Parcel storage needs no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (redirect_v_i) begin
            if (redirect_partial_v_i) begin
                r_parcel[0] <= redirect_partial_i;
                r_pc[0]     <= redirect_pc_i;
            end
        end else if (w_push) begin
            for (int k = 0; k < P; k++) begin
                if (k >= int'(w_offset)) begin
                    r_parcel[r_tail + PW'(k) - PW'(w_offset)] <= fetch_data_i[16*k +: 16];
                    r_pc[r_tail + PW'(k) - PW'(w_offset)]     <=
                        fetch_pc_i + vaddr_width_p'(2 * (k - int'(w_offset)));
                end
            end
        end
    end

endmodule
